// File: rtl/bmp_pixel_extractor.sv
`default_nettype none
// ============================================================================
// Module   : bmp_pixel_extractor
// Purpose  : Splits a 24-bpp BMP byte stream into header/gap bytes and pixel
//            bytes, discarding row padding.
// Revision : 1.0
// ============================================================================
module bmp_pixel_extractor #(
  parameter int FF_DATA_WIDTH = 8,
  parameter int DIM_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [FF_DATA_WIDTH-1:0] src_data,
  input  logic                     src_empty,
  output logic                     src_rd,
  input  logic                     hdr_full,
  output logic [FF_DATA_WIDTH-1:0] hdr_data,
  output logic                     hdr_wr,
  input  logic                     ff_full,
  output logic [FF_DATA_WIDTH-1:0] ff_data,
  output logic                     ff_wr,
  output logic [DIM_W-1:0]         img_width,
  output logic [DIM_W-1:0]         img_height,
  output logic                     hdr_ok,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_FINISH  = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    P_HDR = 2'd0,
    P_GAP = 2'd1,
    P_PIX = 2'd2,
    P_PAD = 2'd3
  } phase_t;

  localparam logic [31:0]      HDR_LEN = 32'd54;
  localparam logic [DIM_W+1:0] COL_ONE = 1;
  localparam logic [DIM_W-1:0] DIM_ONE = 1;

  state_t                   state_q, state_d;
  phase_t                   phase_q, phase_d;
  logic [5:0]               hdr_idx_q, hdr_idx_d;
  logic [7:0]               b0_q, b0_d, b1_q, b1_d;
  logic [31:0]              offset_q, offset_d, width_q, width_d, height_q, height_d;
  logic [15:0]              bpp_q, bpp_d;
  logic [31:0]              gap_rem_q, gap_rem_d;
  logic [DIM_W+1:0]         col_q, col_d;
  logic [DIM_W-1:0]         row_q, row_d;
  logic [1:0]               pad_cnt_q, pad_cnt_d;
  logic [DIM_W-1:0]         img_width_q, img_width_d, img_height_q, img_height_d;
  logic                     hdr_ok_q, hdr_ok_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                     hdr_wr_q, hdr_wr_d, ff_wr_q, ff_wr_d;
  logic [FF_DATA_WIDTH-1:0] hdr_data_q, hdr_data_d, ff_data_q, ff_data_d;

  logic [DIM_W+1:0]         row_bytes;
  logic [1:0]               pad_len;
  logic                     tgt_full;
  logic                     hdr_good;
  logic                     end_row;

  assign row_bytes = {2'b00, img_width_q} + {1'b0, img_width_q, 1'b0};
  assign pad_len   = 2'd0 - row_bytes[1:0];
  assign tgt_full  = (phase_q == P_PIX) ? ff_full : (phase_q == P_PAD) ? 1'b0 : hdr_full;

  // All header fields are already captured by the time byte 53 arrives.
  assign hdr_good = (b0_q == 8'h42) && (b1_q == 8'h4D) && (bpp_q == 16'd24) &&
                    (offset_q >= HDR_LEN) && (width_q != 32'd0) && (height_q != 32'd0) &&
                    ((width_q >> DIM_W) == 32'd0) && ((height_q >> DIM_W) == 32'd0);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hdr_idx_d    = hdr_idx_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    offset_d     = offset_q;
    width_d      = width_q;
    height_d     = height_q;
    bpp_d        = bpp_q;
    gap_rem_d    = gap_rem_q;
    col_d        = col_q;
    row_d        = row_q;
    pad_cnt_d    = pad_cnt_q;
    img_width_d  = img_width_q;
    img_height_d = img_height_q;
    hdr_ok_d     = hdr_ok_q;
    busy_d       = busy_q;
    err_d        = err_q;
    done_d       = 1'b0;
    hdr_wr_d     = 1'b0;
    ff_wr_d      = 1'b0;
    hdr_data_d   = hdr_data_q;
    ff_data_d    = ff_data_q;
    src_rd       = 1'b0;
    end_row      = 1'b0;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d      = S_FETCH;
          phase_d      = P_HDR;
          hdr_idx_d    = 6'd0;
          b0_d         = 8'd0;
          b1_d         = 8'd0;
          offset_d     = 32'd0;
          width_d      = 32'd0;
          height_d     = 32'd0;
          bpp_d        = 16'd0;
          gap_rem_d    = 32'd0;
          col_d        = '0;
          row_d        = '0;
          pad_cnt_d    = 2'd0;
          img_width_d  = '0;
          img_height_d = '0;
          hdr_ok_d     = 1'b0;
          err_d        = 1'b0;
          busy_d       = 1'b1;
        end
      end

      S_FETCH: begin
        // A write still leaving this cycle blocks the read to keep strobes apart.
        if (!src_empty && !tgt_full && !hdr_wr_q && !ff_wr_q) begin
          src_rd  = 1'b1;
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        state_d = S_FETCH;
        case (phase_q)
          P_HDR: begin
            hdr_wr_d   = 1'b1;
            hdr_data_d = src_data;
            hdr_idx_d  = hdr_idx_q + 6'd1;
            if (hdr_idx_q == 6'd0) b0_d = src_data[7:0];
            if (hdr_idx_q == 6'd1) b1_d = src_data[7:0];
            if (hdr_idx_q >= 6'd10 && hdr_idx_q <= 6'd13) offset_d = {src_data[7:0], offset_q[31:8]};
            if (hdr_idx_q >= 6'd18 && hdr_idx_q <= 6'd21) width_d  = {src_data[7:0], width_q[31:8]};
            if (hdr_idx_q >= 6'd22 && hdr_idx_q <= 6'd25) height_d = {src_data[7:0], height_q[31:8]};
            if (hdr_idx_q >= 6'd28 && hdr_idx_q <= 6'd29) bpp_d    = {src_data[7:0], bpp_q[15:8]};
            if (hdr_idx_q == 6'd53) begin
              if (hdr_good) begin
                hdr_ok_d     = 1'b1;
                img_width_d  = width_q[DIM_W-1:0];
                img_height_d = height_q[DIM_W-1:0];
                gap_rem_d    = offset_q - HDR_LEN;
                phase_d      = (offset_q == HDR_LEN) ? P_PIX : P_GAP;
              end else begin
                state_d = S_ERROR;
                err_d   = 1'b1;
                busy_d  = 1'b0;
              end
            end
          end
          P_GAP: begin
            hdr_wr_d   = 1'b1;
            hdr_data_d = src_data;
            gap_rem_d  = gap_rem_q - 32'd1;
            if (gap_rem_q == 32'd1) phase_d = P_PIX;
          end
          P_PIX: begin
            ff_wr_d   = 1'b1;
            ff_data_d = src_data;
            if (col_q == row_bytes - COL_ONE) begin
              col_d = '0;
              if (pad_len == 2'd0) begin
                end_row = 1'b1;
              end else begin
                phase_d   = P_PAD;
                pad_cnt_d = 2'd0;
              end
            end else begin
              col_d = col_q + COL_ONE;
            end
          end
          default: begin
            if (pad_cnt_q == pad_len - 2'd1) end_row = 1'b1;
            else pad_cnt_d = pad_cnt_q + 2'd1;
          end
        endcase

        if (end_row) begin
          if (row_q == img_height_q - DIM_ONE) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            row_d   = row_q + DIM_ONE;
            phase_d = P_PIX;
          end
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= P_HDR;
      hdr_idx_q    <= 6'd0;
      b0_q         <= 8'd0;
      b1_q         <= 8'd0;
      offset_q     <= 32'd0;
      width_q      <= 32'd0;
      height_q     <= 32'd0;
      bpp_q        <= 16'd0;
      gap_rem_q    <= 32'd0;
      col_q        <= '0;
      row_q        <= '0;
      pad_cnt_q    <= 2'd0;
      img_width_q  <= '0;
      img_height_q <= '0;
      hdr_ok_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      hdr_wr_q     <= 1'b0;
      ff_wr_q      <= 1'b0;
      hdr_data_q   <= '0;
      ff_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      hdr_idx_q    <= hdr_idx_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      offset_q     <= offset_d;
      width_q      <= width_d;
      height_q     <= height_d;
      bpp_q        <= bpp_d;
      gap_rem_q    <= gap_rem_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pad_cnt_q    <= pad_cnt_d;
      img_width_q  <= img_width_d;
      img_height_q <= img_height_d;
      hdr_ok_q     <= hdr_ok_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      hdr_wr_q     <= hdr_wr_d;
      ff_wr_q      <= ff_wr_d;
      hdr_data_q   <= hdr_data_d;
      ff_data_q    <= ff_data_d;
    end
  end

  assign hdr_data   = hdr_data_q;
  assign hdr_wr     = hdr_wr_q;
  assign ff_data    = ff_data_q;
  assign ff_wr      = ff_wr_q;
  assign img_width  = img_width_q;
  assign img_height = img_height_q;
  assign hdr_ok     = hdr_ok_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
`default_nettype wire
